// File: rtl/spi_sensor_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_sensor_reader : sequences cmd/addr/dummy-byte register reads through an
// SPI byte master and publishes the returned bytes as a little-endian sample.
// Revision 1.0
// ---------------------------------------------------------------------------
module spi_sensor_reader #(
  parameter int         SPI_SIZE    = 2,
  parameter int         SENSOR_CODE = 1,
  parameter int         IDLE_CODE   = 0,
  parameter logic [7:0] CMD_BYTE    = 8'h0B,
  parameter logic [7:0] ADDR_BYTE   = 8'h0E,
  parameter int         NUM_BYTES   = 2,
  parameter int         PERIOD      = 100000,
  parameter int         GAP_CYCLES  = 4,
  parameter int         TIMEOUT     = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   start,
  output logic [7:0]             tx_byte,
  output logic                   tx_dv,
  input  logic                   tx_ready,
  input  logic                   rx_dv,
  input  logic [7:0]             rx_byte,
  output logic [SPI_SIZE-1:0]    spi_code,
  output logic [8*NUM_BYTES-1:0] sample,
  output logic                   sample_valid,
  output logic                   busy,
  output logic                   timeout_err,
  output logic                   overrun
);

  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int KW = 3;

  localparam logic [KW-1:0]       LAST_K      = KW'(NUM_BYTES + 1);
  localparam logic [SPI_SIZE-1:0] C_SENSOR    = SPI_SIZE'(SENSOR_CODE);
  localparam logic [SPI_SIZE-1:0] C_IDLE      = SPI_SIZE'(IDLE_CODE);
  localparam logic [PW-1:0]       PERIOD_LAST = PW'(PERIOD - 1);
  localparam logic [TW-1:0]       TO_LAST     = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0]       GAP_LAST    = (GAP_CYCLES > 1) ? GW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_TX, WAIT_RX, GAP} state_t;

  state_t                   state, state_nx;
  logic [PW-1:0]            per_cnt;
  logic [TW-1:0]            t_cnt;
  logic [GW-1:0]            g_cnt;
  logic [KW-1:0]            k;
  logic [8*NUM_BYTES-1:0]   acc;
  logic                     done;
  logic                     wrap;
  logic                     req;

  // Wrap and start in the same cycle collapse into a single request.
  assign wrap = (PERIOD != 0) && enable && (per_cnt == PERIOD_LAST);
  assign req  = enable && (start || wrap);

  always_ff @(posedge clk) begin
    if (rst || !enable || PERIOD == 0 || wrap) per_cnt <= '0;
    else                                       per_cnt <= per_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req) state_nx = LOAD;
      LOAD:    state_nx = WAIT_TX;
      WAIT_TX: if (tx_ready) state_nx = WAIT_RX;
      WAIT_RX: begin
        if (rx_dv)                 state_nx = (k == LAST_K) ? GAP : LOAD;
        else if (t_cnt == TO_LAST) state_nx = GAP;
      end
      GAP:     if (g_cnt == GAP_LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_byte      <= '0;
      tx_dv        <= 1'b0;
      spi_code     <= C_IDLE;
      sample       <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
      overrun      <= 1'b0;
      t_cnt        <= '0;
      g_cnt        <= '0;
      k            <= '0;
      acc          <= '0;
      done         <= 1'b0;
    end else begin
      tx_dv        <= 1'b0;
      sample_valid <= 1'b0;
      busy         <= (state_nx != IDLE);
      if (req && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (req) begin
            spi_code <= C_SENSOR;
            k        <= '0;
            done     <= 1'b0;
          end
        end
        LOAD: begin
          case (k)
            KW'(0):  tx_byte <= CMD_BYTE;
            KW'(1):  tx_byte <= ADDR_BYTE;
            default: tx_byte <= 8'h00;
          endcase
        end
        WAIT_TX: begin
          if (tx_ready) begin
            tx_dv <= 1'b1;
            t_cnt <= '0;
          end
        end
        WAIT_RX: begin
          t_cnt <= t_cnt + 1'b1;
          if (rx_dv) begin
            // Bytes 0 and 1 are the cmd/addr echo; data lands little-endian.
            for (int i = 0; i < NUM_BYTES; i++) begin
              if (k == KW'(i + 2)) acc[8*i +: 8] <= rx_byte;
            end
            if (k == LAST_K) begin
              done  <= 1'b1;
              g_cnt <= '0;
            end else begin
              k <= k + 1'b1;
            end
          end else if (t_cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            done        <= 1'b0;
            g_cnt       <= '0;
          end
        end
        GAP: begin
          g_cnt <= g_cnt + 1'b1;
          if (g_cnt == GAP_LAST) begin
            spi_code <= C_IDLE;
            if (done) begin
              sample       <= acc;
              sample_valid <= 1'b1;
              timeout_err  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_sensor_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_spi_sensor_reader : directed vectors for a manual-start instance and a
// periodic instance, each served by a byte-level SPI master model.
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_spi_sensor_reader;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      enable, start, tx_ready, rx_dv, tx_dv, sample_valid, busy, timeout_err, overrun;
  logic [1:0][7:0] rx_byte, tx_byte;
  logic [1:0][1:0] spi_code;
  logic [1:0][15:0] sample;

  spi_sensor_reader #(.SPI_SIZE(2), .SENSOR_CODE(1), .IDLE_CODE(0), .CMD_BYTE(8'h0B),
    .ADDR_BYTE(8'h0E), .NUM_BYTES(2), .PERIOD(0), .GAP_CYCLES(4), .TIMEOUT(32)) u_man (
    .clk(clk), .rst(rst), .enable(enable[0]), .start(start[0]), .tx_byte(tx_byte[0]),
    .tx_dv(tx_dv[0]), .tx_ready(tx_ready[0]), .rx_dv(rx_dv[0]), .rx_byte(rx_byte[0]),
    .spi_code(spi_code[0]), .sample(sample[0]), .sample_valid(sample_valid[0]),
    .busy(busy[0]), .timeout_err(timeout_err[0]), .overrun(overrun[0]));

  spi_sensor_reader #(.SPI_SIZE(2), .SENSOR_CODE(1), .IDLE_CODE(0), .CMD_BYTE(8'h0B),
    .ADDR_BYTE(8'h0E), .NUM_BYTES(2), .PERIOD(200), .GAP_CYCLES(4), .TIMEOUT(32)) u_per (
    .clk(clk), .rst(rst), .enable(enable[1]), .start(start[1]), .tx_byte(tx_byte[1]),
    .tx_dv(tx_dv[1]), .tx_ready(tx_ready[1]), .rx_dv(rx_dv[1]), .rx_byte(rx_byte[1]),
    .spi_code(spi_code[1]), .sample(sample[1]), .sample_valid(sample_valid[1]),
    .busy(busy[1]), .timeout_err(timeout_err[1]), .overrun(overrun[1]));

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int         n_vec = 0;
  int         n_err = 0;
  int         n_tx[2], n_sv[2], last_rx_t[2], fall_t[2], terr_t[2];
  int         dv_t[2][32];
  logic [7:0] txlog[2][32];
  bit         spi_bad[2];
  logic       prev_spi1[2], prev_terr[2];
  int         pend[2], ridx[2], drop_after[2];
  logic [7:0] pbyte[2];
  logic [7:0] resp[2][4];
  bit         stray[2];
  logic [7:0] stray_b[2];

  // Monitor first, then the master model updates rx_dv for the next edge.
  initial begin
    rx_dv   = '0;
    rx_byte = '0;
    forever begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        if (tx_dv[u] === 1'b1) begin
          if (n_tx[u] < 32) begin
            dv_t[u][n_tx[u]]  = cyc;
            txlog[u][n_tx[u]] = tx_byte[u];
          end
          n_tx[u]++;
          if (spi_code[u] != 2'd1) spi_bad[u] = 1'b1;
        end
        if (busy[u] !== (spi_code[u] == 2'd1)) spi_bad[u] = 1'b1;
        if (sample_valid[u] === 1'b1) n_sv[u]++;
        if (rx_dv[u]) last_rx_t[u] = cyc;
        if (prev_spi1[u] && spi_code[u] == 2'd0) fall_t[u] = cyc;
        if (!prev_terr[u] && timeout_err[u] === 1'b1) terr_t[u] = cyc;
        prev_spi1[u] = (spi_code[u] == 2'd1);
        prev_terr[u] = (timeout_err[u] === 1'b1);
        rx_dv[u] = 1'b0;
        if (rst) pend[u] = 0;
        else if (pend[u] > 0) begin
          pend[u]--;
          if (pend[u] == 0) begin
            rx_dv[u]   = 1'b1;
            rx_byte[u] = pbyte[u];
          end
        end
        if (!rst && tx_dv[u] === 1'b1) begin
          if (ridx[u] < drop_after[u]) begin
            pend[u]  = 3;
            pbyte[u] = resp[u][ridx[u] % 4];
          end
          ridx[u]++;
        end
        if (stray[u]) begin
          rx_dv[u]   = 1'b1;
          rx_byte[u] = stray_b[u];
          stray[u]   = 1'b0;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d required < 100000", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clr(input int u);
    n_tx[u] = 0; n_sv[u] = 0; last_rx_t[u] = -1000; fall_t[u] = -1; terr_t[u] = -1;
    spi_bad[u] = 1'b0; ridx[u] = 0; drop_after[u] = 99;
  endtask

  typedef struct packed {
    logic [7:0]  r0, r1, d0, d1;
    logic [15:0] exp;
  } vec_t;

  task automatic load_resp(input int u, input vec_t v);
    resp[u][0] = v.r0; resp[u][1] = v.r1; resp[u][2] = v.d0; resp[u][3] = v.d1;
  endtask

  task automatic pulse_start(input int u);
    start[u] = 1'b1;
    step();
    start[u] = 1'b0;
  endtask

  task automatic wait_sv(input int u, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      if (n_sv[u] != 0) ok = 1'b1;
    end
  endtask

  task automatic chk_reset(input int u);
    chk("rst_tx_byte", 32'(tx_byte[u]), 32'h0);
    chk("rst_tx_dv", 32'(tx_dv[u]), 32'h0);
    chk("rst_spi_code", 32'(spi_code[u]), 32'h0);
    chk("rst_sample", 32'(sample[u]), 32'h0);
    chk("rst_sample_valid", 32'(sample_valid[u]), 32'h0);
    chk("rst_busy", 32'(busy[u]), 32'h0);
    chk("rst_timeout_err", 32'(timeout_err[u]), 32'h0);
    chk("rst_overrun", 32'(overrun[u]), 32'h0);
  endtask

  // One complete manual read; response bytes must already be loaded.
  task automatic full_read(input int u, input logic [15:0] exp);
    bit ok;
    clr(u);
    pulse_start(u);
    wait_sv(u, 300, ok);
    chk("read_sv_seen", 32'(ok), 32'h1);
    chk("read_sample", 32'(sample[u]), 32'(exp));
    chk("read_terr_clear", 32'(timeout_err[u]), 32'h0);
    repeat (3) step();
    chk("read_ntx", 32'(n_tx[u]), 32'd4);
    chk("read_bytes", {txlog[u][0], txlog[u][1], txlog[u][2], txlog[u][3]}, 32'h0B0E0000);
    chk("read_nsv", 32'(n_sv[u]), 32'd1);
    chk("read_spi_idle", 32'(spi_code[u]), 32'h0);
    chk("read_busy_idle", 32'(busy[u]), 32'h0);
    chk("read_spi_held", 32'(spi_bad[u]), 32'h0);
    chk("read_gap_len", 32'(fall_t[u] - last_rx_t[u]), 32'd4);
  endtask

  vec_t       vt[4];
  logic [15:0] last_good;
  bit          ok;
  int          c0;

  initial begin
    vt[0] = '{8'hAA, 8'hBB, 8'h34, 8'h12, 16'h1234};
    vt[1] = '{8'h00, 8'h00, 8'hFF, 8'h00, 16'h00FF};
    vt[2] = '{8'h5A, 8'hA5, 8'hCD, 8'hAB, 16'hABCD};
    vt[3] = '{8'hFF, 8'hFF, 8'h00, 8'h80, 16'h8000};

    rst = 1'b1; enable = '0; start = '0; tx_ready = 2'b11;
    clr(0); clr(1);
    load_resp(0, vt[0]); load_resp(1, vt[0]);
    stray[0] = 1'b0; stray[1] = 1'b0;
    repeat (3) step();
    chk_reset(0);
    chk_reset(1);
    rst = 1'b0;
    enable[0] = 1'b1;
    step();

    // Table-driven normal reads.
    for (int i = 0; i < 4; i++) begin
      load_resp(0, vt[i]);
      full_read(0, vt[i].exp);
      step();
    end

    // Ready backpressure: no strobe while tx_ready is low, cmd byte held.
    load_resp(0, vt[0]);
    clr(0);
    tx_ready[0] = 1'b0;
    pulse_start(0);
    repeat (50) step();
    chk("bp_no_dv", 32'(n_tx[0]), 32'd0);
    chk("bp_tx_byte", 32'(tx_byte[0]), 32'h0B);
    chk("bp_busy", 32'(busy[0]), 32'h1);
    tx_ready[0] = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 10 && n_tx[0] == 0; i++) step();
    chk("bp_dv_latency", 32'(dv_t[0][0] - c0), 32'd1);
    chk("bp_dv_byte", 32'(txlog[0][0]), 32'h0B);
    wait_sv(0, 300, ok);
    chk("bp_sample", 32'(sample[0]), 32'h1234);
    last_good = 16'h1234;
    repeat (3) step();
    chk("bp_ntx", 32'(n_tx[0]), 32'd4);

    // Timeout: the third byte is never answered.
    load_resp(0, vt[2]);
    clr(0);
    drop_after[0] = 2;
    pulse_start(0);
    for (int i = 0; i < 300 && terr_t[0] < 0; i++) step();
    chk("to_seen", 32'(terr_t[0] >= 0), 32'h1);
    chk("to_delay", 32'(terr_t[0] - dv_t[0][2]), 32'd32);
    repeat (10) step();
    chk("to_err_sticky", 32'(timeout_err[0]), 32'h1);
    chk("to_sample_kept", 32'(sample[0]), 32'(last_good));
    chk("to_no_sv", 32'(n_sv[0]), 32'd0);
    chk("to_ntx", 32'(n_tx[0]), 32'd3);
    chk("to_spi_idle", 32'(spi_code[0]), 32'h0);
    chk("to_busy_idle", 32'(busy[0]), 32'h0);
    full_read(0, 16'hABCD);

    // Overrun: a second start while busy is dropped.
    load_resp(0, vt[1]);
    chk("ovr_init", 32'(overrun[0]), 32'h0);
    clr(0);
    pulse_start(0);
    repeat (5) step();
    pulse_start(0);
    chk("ovr_set", 32'(overrun[0]), 32'h1);
    wait_sv(0, 300, ok);
    chk("ovr_sample", 32'(sample[0]), 32'h00FF);
    repeat (40) step();
    chk("ovr_ntx", 32'(n_tx[0]), 32'd4);
    chk("ovr_nsv", 32'(n_sv[0]), 32'd1);
    chk("ovr_sticky", 32'(overrun[0]), 32'h1);

    // A stray rx_dv while idle is ignored.
    clr(0);
    stray_b[0] = 8'h77;
    stray[0]   = 1'b1;
    repeat (5) step();
    chk("stray_sample", 32'(sample[0]), 32'h00FF);
    chk("stray_no_sv", 32'(n_sv[0]), 32'd0);
    chk("stray_busy", 32'(busy[0]), 32'h0);

    // Periodic: 1000 enabled cycles give 5 transactions 200 cycles apart.
    clr(1);
    enable[1] = 1'b1;
    c0 = cyc;
    repeat (1000) step();
    enable[1] = 1'b0;
    repeat (500) step();
    chk("per_nsv", 32'(n_sv[1]), 32'd5);
    chk("per_ntx", 32'(n_tx[1]), 32'd20);
    chk("per_first_dv", 32'(dv_t[1][0] - c0), 32'd202);
    for (int t = 1; t < 5; t++)
      chk("per_spacing", 32'(dv_t[1][4*t] - dv_t[1][4*(t-1)]), 32'd200);
    chk("per_sample", 32'(sample[1]), 32'h1234);
    chk("per_no_overrun", 32'(overrun[1]), 32'h0);
    chk("per_spi_held", 32'(spi_bad[1]), 32'h0);

    // Start coinciding with the timer wrap launches exactly one read.
    clr(1);
    enable[1] = 1'b1;
    c0 = cyc;
    repeat (199) step();
    start[1] = 1'b1;
    step();
    start[1]  = 1'b0;
    enable[1] = 1'b0;
    repeat (60) step();
    chk("coinc_ntx", 32'(n_tx[1]), 32'd4);
    chk("coinc_nsv", 32'(n_sv[1]), 32'd1);
    chk("coinc_first_dv", 32'(dv_t[1][0] - c0), 32'd202);
    chk("coinc_no_overrun", 32'(overrun[1]), 32'h0);

    // Reset while waiting for the third byte's reply.
    load_resp(0, vt[3]);
    clr(0);
    pulse_start(0);
    for (int i = 0; i < 300 && n_tx[0] < 3; i++) step();
    chk("mid_reached", 32'(n_tx[0]), 32'd3);
    step();
    rst = 1'b1;
    step();
    chk_reset(0);
    rst = 1'b0;
    step();
    full_read(0, 16'h8000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
